// File: rtl/axi_lite_to_axi.sv
// AXI4-Lite to AXI4 bridge: every Lite access becomes a single-beat INCR burst with fixed ID/USER.
// Zero-cycle combinational channels; AR/AW/W hold valid and ready low while their outstanding limit is reached.
module axi_lite_to_axi #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ID_WIDTH       = 4,
   parameter int unsigned USER_WIDTH     = 1,
   parameter int unsigned NUM_PENDING_RD = 1,
   parameter int unsigned NUM_PENDING_WR = 1,
   parameter int unsigned AXI_ID         = 0,
   parameter int unsigned AXI_USER       = 0,
   localparam int unsigned RD_CW         = $clog2(NUM_PENDING_RD + 1),
   localparam int unsigned WR_CW         = $clog2(NUM_PENDING_WR + 1),
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,

   // Lite slave side
   input  logic [ADDR_WIDTH-1:0] in_aw_addr,
   input  logic [2:0]            in_aw_prot,
   input  logic                  in_aw_valid,
   output logic                  in_aw_ready,
   input  logic [DATA_WIDTH-1:0] in_w_data,
   input  logic [STRB_WIDTH-1:0] in_w_strb,
   input  logic                  in_w_valid,
   output logic                  in_w_ready,
   output logic [1:0]            in_b_resp,
   output logic                  in_b_valid,
   input  logic                  in_b_ready,
   input  logic [ADDR_WIDTH-1:0] in_ar_addr,
   input  logic [2:0]            in_ar_prot,
   input  logic                  in_ar_valid,
   output logic                  in_ar_ready,
   output logic [DATA_WIDTH-1:0] in_r_data,
   output logic [1:0]            in_r_resp,
   output logic                  in_r_valid,
   input  logic                  in_r_ready,

   // AXI4 master side
   output logic [ID_WIDTH-1:0]   out_aw_id,
   output logic [ADDR_WIDTH-1:0] out_aw_addr,
   output logic [7:0]            out_aw_len,
   output logic [2:0]            out_aw_size,
   output logic [1:0]            out_aw_burst,
   output logic                  out_aw_lock,
   output logic [3:0]            out_aw_cache,
   output logic [2:0]            out_aw_prot,
   output logic [3:0]            out_aw_qos,
   output logic [3:0]            out_aw_region,
   output logic [USER_WIDTH-1:0] out_aw_user,
   output logic                  out_aw_valid,
   input  logic                  out_aw_ready,
   output logic [DATA_WIDTH-1:0] out_w_data,
   output logic [STRB_WIDTH-1:0] out_w_strb,
   output logic                  out_w_last,
   output logic [USER_WIDTH-1:0] out_w_user,
   output logic                  out_w_valid,
   input  logic                  out_w_ready,
   input  logic [ID_WIDTH-1:0]   out_b_id,
   input  logic [1:0]            out_b_resp,
   input  logic [USER_WIDTH-1:0] out_b_user,
   input  logic                  out_b_valid,
   output logic                  out_b_ready,
   output logic [ID_WIDTH-1:0]   out_ar_id,
   output logic [ADDR_WIDTH-1:0] out_ar_addr,
   output logic [7:0]            out_ar_len,
   output logic [2:0]            out_ar_size,
   output logic [1:0]            out_ar_burst,
   output logic                  out_ar_lock,
   output logic [3:0]            out_ar_cache,
   output logic [2:0]            out_ar_prot,
   output logic [3:0]            out_ar_qos,
   output logic [3:0]            out_ar_region,
   output logic [USER_WIDTH-1:0] out_ar_user,
   output logic                  out_ar_valid,
   input  logic                  out_ar_ready,
   input  logic [ID_WIDTH-1:0]   out_r_id,
   input  logic [DATA_WIDTH-1:0] out_r_data,
   input  logic [1:0]            out_r_resp,
   input  logic                  out_r_last,
   input  logic [USER_WIDTH-1:0] out_r_user,
   input  logic                  out_r_valid,
   output logic                  out_r_ready,

   output logic [RD_CW-1:0]      rd_pending_o,
   output logic [WR_CW-1:0]      wr_pending_o,
   output logic                  err_o
);

   localparam logic [RD_CW-1:0]      RD_MAX     = RD_CW'(NUM_PENDING_RD);
   localparam logic [WR_CW-1:0]      WR_MAX     = WR_CW'(NUM_PENDING_WR);
   localparam logic [ID_WIDTH-1:0]   ID_CONST   = ID_WIDTH'(AXI_ID);
   localparam logic [USER_WIDTH-1:0] USER_CONST = USER_WIDTH'(AXI_USER);
   localparam logic [2:0]            BEAT_SIZE  = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [1:0]            BURST_INCR = 2'b01;

   logic [RD_CW-1:0] rd_cnt;
   logic [WR_CW-1:0] aw_cnt;
   logic [WR_CW-1:0] w_cnt;
   logic             err_q;

   logic rd_room, aw_room, w_room;
   logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic r_err, b_err;

   // Room is judged on registered counts only, so responses never feed back into request gating combinationally.
   assign rd_room = (rd_cnt != RD_MAX);
   assign aw_room = (aw_cnt != WR_MAX);
   assign w_room  = (w_cnt  != WR_MAX);

   // AR channel
   assign out_ar_valid  = in_ar_valid & rd_room;
   assign in_ar_ready   = out_ar_ready & rd_room;
   assign out_ar_addr   = in_ar_addr;
   assign out_ar_prot   = in_ar_prot;
   assign out_ar_id     = ID_CONST;
   assign out_ar_len    = 8'd0;
   assign out_ar_size   = BEAT_SIZE;
   assign out_ar_burst  = BURST_INCR;
   assign out_ar_lock   = 1'b0;
   assign out_ar_cache  = 4'b0000;
   assign out_ar_qos    = 4'd0;
   assign out_ar_region = 4'd0;
   assign out_ar_user   = USER_CONST;

   // AW channel
   assign out_aw_valid  = in_aw_valid & aw_room;
   assign in_aw_ready   = out_aw_ready & aw_room;
   assign out_aw_addr   = in_aw_addr;
   assign out_aw_prot   = in_aw_prot;
   assign out_aw_id     = ID_CONST;
   assign out_aw_len    = 8'd0;
   assign out_aw_size   = BEAT_SIZE;
   assign out_aw_burst  = BURST_INCR;
   assign out_aw_lock   = 1'b0;
   assign out_aw_cache  = 4'b0000;
   assign out_aw_qos    = 4'd0;
   assign out_aw_region = 4'd0;
   assign out_aw_user   = USER_CONST;

   // W channel, independent of AW ordering
   assign out_w_valid = in_w_valid & w_room;
   assign in_w_ready  = out_w_ready & w_room;
   assign out_w_data  = in_w_data;
   assign out_w_strb  = in_w_strb;
   assign out_w_last  = 1'b1;
   assign out_w_user  = USER_CONST;

   // Response channels pass straight through
   assign in_r_valid  = out_r_valid;
   assign out_r_ready = in_r_ready;
   assign in_r_data   = out_r_data;
   assign in_r_resp   = out_r_resp;
   assign in_b_valid  = out_b_valid;
   assign out_b_ready = in_b_ready;
   assign in_b_resp   = out_b_resp;

   assign ar_hs = out_ar_valid & out_ar_ready;
   assign aw_hs = out_aw_valid & out_aw_ready;
   assign w_hs  = out_w_valid & out_w_ready;
   assign r_hs  = out_r_valid & in_r_ready;
   assign b_hs  = out_b_valid & in_b_ready;

   assign r_err = r_hs & (~out_r_last | (rd_cnt == '0));
   assign b_err = b_hs & ((aw_cnt == '0) | (w_cnt == '0));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_cnt <= '0;
      end else if (ar_hs && !r_hs) begin
         rd_cnt <= rd_cnt + RD_CW'(1);
      end else if (r_hs && !ar_hs && (rd_cnt != '0)) begin
         rd_cnt <= rd_cnt - RD_CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         aw_cnt <= '0;
      end else if (aw_hs && !b_hs) begin
         aw_cnt <= aw_cnt + WR_CW'(1);
      end else if (b_hs && !aw_hs && (aw_cnt != '0)) begin
         aw_cnt <= aw_cnt - WR_CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         w_cnt <= '0;
      end else if (w_hs && !b_hs) begin
         w_cnt <= w_cnt + WR_CW'(1);
      end else if (b_hs && !w_hs && (w_cnt != '0)) begin
         w_cnt <= w_cnt - WR_CW'(1);
      end
   end

   // Unexpected or malformed responses latch until reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (r_err || b_err) begin
         err_q <= 1'b1;
      end
   end

   assign rd_pending_o = rd_cnt;
   assign wr_pending_o = aw_cnt;
   assign err_o        = err_q;

   // Burst-only response fields are intentionally dropped
   logic unused_resp_fields;
   assign unused_resp_fields = ^{out_r_user, out_b_user};

`ifndef SYNTHESIS
   param_chk: assert property (@(posedge clk_i)
      (NUM_PENDING_RD > 0) && (NUM_PENDING_WR > 0) && ((64'(AXI_ID) >> ID_WIDTH) == 64'd0)
      && (STRB_WIDTH * 8 == DATA_WIDTH))
      else $error("axi_lite_to_axi: illegal parameterisation");
   r_id_chk: assert property (@(posedge clk_i) disable iff (rst_i) r_hs |-> (out_r_id == ID_CONST))
      else $error("axi_lite_to_axi: r_id differs from AXI_ID");
   b_id_chk: assert property (@(posedge clk_i) disable iff (rst_i) b_hs |-> (out_b_id == ID_CONST))
      else $error("axi_lite_to_axi: b_id differs from AXI_ID");
`endif

endmodule

// File: tb/tb_axi_lite_to_axi.sv
// Randomised and directed bench for axi_lite_to_axi against an integer outstanding-count model.
module tb_axi_lite_to_axi;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int IDW  = 4;
   localparam int UW   = 2;
   localparam int PRD  = 2;
   localparam int PWR  = 2;
   localparam int AID  = 3;
   localparam int AUSR = 2;
   localparam logic [31:0] FIX_EXP = {4'(AID), 8'd0, 3'd2, 2'b01, 1'b0, 12'd0, 2'(AUSR)};

   logic clk_i, rst_i;
   logic [AW-1:0] in_aw_addr, in_ar_addr, out_aw_addr, out_ar_addr;
   logic [2:0]    in_aw_prot, in_ar_prot, out_aw_prot, out_ar_prot;
   logic          in_aw_valid, in_aw_ready, in_w_valid, in_w_ready, in_b_valid, in_b_ready;
   logic          in_ar_valid, in_ar_ready, in_r_valid, in_r_ready;
   logic [DW-1:0] in_w_data, in_r_data, out_w_data, out_r_data;
   logic [3:0]    in_w_strb, out_w_strb;
   logic [1:0]    in_b_resp, in_r_resp, out_b_resp, out_r_resp;
   logic [IDW-1:0] out_aw_id, out_ar_id, out_b_id, out_r_id;
   logic [7:0]    out_aw_len, out_ar_len;
   logic [2:0]    out_aw_size, out_ar_size;
   logic [1:0]    out_aw_burst, out_ar_burst;
   logic          out_aw_lock, out_ar_lock;
   logic [3:0]    out_aw_cache, out_ar_cache, out_aw_qos, out_ar_qos, out_aw_region, out_ar_region;
   logic [UW-1:0] out_aw_user, out_ar_user, out_w_user, out_b_user, out_r_user;
   logic          out_aw_valid, out_aw_ready, out_w_last, out_w_valid, out_w_ready;
   logic          out_b_valid, out_b_ready, out_ar_valid, out_ar_ready;
   logic          out_r_last, out_r_valid, out_r_ready;
   logic [1:0]    rd_pending_o, wr_pending_o;
   logic          err_o;

   axi_lite_to_axi #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .USER_WIDTH(UW),
      .NUM_PENDING_RD(PRD), .NUM_PENDING_WR(PWR), .AXI_ID(AID), .AXI_USER(AUSR)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .in_aw_addr(in_aw_addr), .in_aw_prot(in_aw_prot), .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready),
      .in_w_data(in_w_data), .in_w_strb(in_w_strb), .in_w_valid(in_w_valid), .in_w_ready(in_w_ready),
      .in_b_resp(in_b_resp), .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
      .in_ar_addr(in_ar_addr), .in_ar_prot(in_ar_prot), .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready),
      .in_r_data(in_r_data), .in_r_resp(in_r_resp), .in_r_valid(in_r_valid), .in_r_ready(in_r_ready),
      .out_aw_id(out_aw_id), .out_aw_addr(out_aw_addr), .out_aw_len(out_aw_len), .out_aw_size(out_aw_size),
      .out_aw_burst(out_aw_burst), .out_aw_lock(out_aw_lock), .out_aw_cache(out_aw_cache),
      .out_aw_prot(out_aw_prot), .out_aw_qos(out_aw_qos), .out_aw_region(out_aw_region),
      .out_aw_user(out_aw_user), .out_aw_valid(out_aw_valid), .out_aw_ready(out_aw_ready),
      .out_w_data(out_w_data), .out_w_strb(out_w_strb), .out_w_last(out_w_last), .out_w_user(out_w_user),
      .out_w_valid(out_w_valid), .out_w_ready(out_w_ready),
      .out_b_id(out_b_id), .out_b_resp(out_b_resp), .out_b_user(out_b_user), .out_b_valid(out_b_valid),
      .out_b_ready(out_b_ready),
      .out_ar_id(out_ar_id), .out_ar_addr(out_ar_addr), .out_ar_len(out_ar_len), .out_ar_size(out_ar_size),
      .out_ar_burst(out_ar_burst), .out_ar_lock(out_ar_lock), .out_ar_cache(out_ar_cache),
      .out_ar_prot(out_ar_prot), .out_ar_qos(out_ar_qos), .out_ar_region(out_ar_region),
      .out_ar_user(out_ar_user), .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready),
      .out_r_id(out_r_id), .out_r_data(out_r_data), .out_r_resp(out_r_resp), .out_r_last(out_r_last),
      .out_r_user(out_r_user), .out_r_valid(out_r_valid), .out_r_ready(out_r_ready),
      .rd_pending_o(rd_pending_o), .wr_pending_o(wr_pending_o), .err_o(err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad = 0;
   // Reference model: outstanding transactions per channel as plain integers
   int m_rd = 0, m_aw = 0, m_w = 0;
   bit m_err = 1'b0;
   int n_ar_hs = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      in_aw_addr = '0; in_aw_prot = '0; in_aw_valid = 1'b0;
      in_w_data = '0; in_w_strb = '0; in_w_valid = 1'b0; in_b_ready = 1'b0;
      in_ar_addr = '0; in_ar_prot = '0; in_ar_valid = 1'b0; in_r_ready = 1'b0;
      out_aw_ready = 1'b0; out_w_ready = 1'b0; out_ar_ready = 1'b0;
      out_b_id = IDW'(AID); out_b_resp = '0; out_b_user = '0; out_b_valid = 1'b0;
      out_r_id = IDW'(AID); out_r_data = '0; out_r_resp = '0; out_r_last = 1'b1;
      out_r_user = '0; out_r_valid = 1'b0;
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic cycle();
      bit ar_ok, aw_ok, w_ok, ar_hs, aw_hs, w_hs, r_hs, b_hs;
      #1;
      ar_ok = (m_rd < PRD);
      aw_ok = (m_aw < PWR);
      w_ok  = (m_w < PWR);
      chk("rd_pend", 64'(rd_pending_o), 64'(m_rd));
      chk("wr_pend", 64'(wr_pending_o), 64'(m_aw));
      chk("err", 64'(err_o), 64'(m_err));
      chk("ar_vld", 64'(out_ar_valid), 64'(in_ar_valid && ar_ok));
      chk("ar_rdy", 64'(in_ar_ready), 64'(out_ar_ready && ar_ok));
      chk("aw_vld", 64'(out_aw_valid), 64'(in_aw_valid && aw_ok));
      chk("aw_rdy", 64'(in_aw_ready), 64'(out_aw_ready && aw_ok));
      chk("w_vld", 64'(out_w_valid), 64'(in_w_valid && w_ok));
      chk("w_rdy", 64'(in_w_ready), 64'(out_w_ready && w_ok));
      chk("r_hsk", {in_r_valid, out_r_ready}, {out_r_valid, in_r_ready});
      chk("b_hsk", {in_b_valid, out_b_ready}, {out_b_valid, in_b_ready});
      chk("r_dat", {in_r_data, in_r_resp}, {out_r_data, out_r_resp});
      chk("b_resp", 64'(in_b_resp), 64'(out_b_resp));
      chk("ar_pass", {out_ar_addr, out_ar_prot}, {in_ar_addr, in_ar_prot});
      chk("aw_pass", {out_aw_addr, out_aw_prot}, {in_aw_addr, in_aw_prot});
      chk("w_pass", {out_w_data, out_w_strb}, {in_w_data, in_w_strb});
      chk("ar_fix", {out_ar_id, out_ar_len, out_ar_size, out_ar_burst, out_ar_lock,
                     out_ar_cache, out_ar_qos, out_ar_region, out_ar_user}, 64'(FIX_EXP));
      chk("aw_fix", {out_aw_id, out_aw_len, out_aw_size, out_aw_burst, out_aw_lock,
                     out_aw_cache, out_aw_qos, out_aw_region, out_aw_user}, 64'(FIX_EXP));
      chk("w_fix", {out_w_last, out_w_user}, {1'b1, 2'(AUSR)});
      if (in_ar_valid && in_ar_ready) n_ar_hs++;
      ar_hs = in_ar_valid && out_ar_ready && ar_ok;
      aw_hs = in_aw_valid && out_aw_ready && aw_ok;
      w_hs  = in_w_valid && out_w_ready && w_ok;
      r_hs  = out_r_valid && in_r_ready;
      b_hs  = out_b_valid && in_b_ready;
      @(posedge clk_i);
      if (r_hs && (!out_r_last || m_rd == 0)) m_err = 1'b1;
      if (b_hs && (m_aw == 0 || m_w == 0)) m_err = 1'b1;
      m_rd = m_rd + int'(ar_hs) - int'(r_hs); if (m_rd < 0) m_rd = 0;
      m_aw = m_aw + int'(aw_hs) - int'(b_hs); if (m_aw < 0) m_aw = 0;
      m_w  = m_w  + int'(w_hs)  - int'(b_hs); if (m_w  < 0) m_w  = 0;
      @(negedge clk_i);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40 && (m_rd > 0 || m_aw > 0 || m_w > 0); i++) begin
         idle();
         in_aw_valid = (m_aw < m_w); out_aw_ready = 1'b1;
         in_w_valid = (m_w < m_aw); out_w_ready = 1'b1;
         out_r_valid = (m_rd > 0); in_r_ready = 1'b1;
         out_b_valid = (m_aw > 0 && m_w > 0); in_b_ready = 1'b1;
         cycle();
      end
      idle();
      chk({tag, "_model_empty"}, 64'(m_rd + m_aw + m_w), 64'd0);
      chk({tag, "_rd_pend"}, 64'(rd_pending_o), 64'd0);
      chk({tag, "_wr_pend"}, 64'(wr_pending_o), 64'd0);
   endtask

   task automatic single_read(input string tag, input logic [31:0] addr, input logic [31:0] data);
      idle();
      in_ar_valid = 1'b1; in_ar_addr = addr; out_ar_ready = 1'b1;
      #1;
      chk({tag, "_ar_addr"}, 64'(out_ar_addr), 64'(addr));
      chk({tag, "_ar_len"}, 64'(out_ar_len), 64'd0);
      chk({tag, "_ar_id"}, 64'(out_ar_id), 64'(AID));
      chk({tag, "_ar_size"}, 64'(out_ar_size), 64'd2);
      chk({tag, "_pend0"}, 64'(rd_pending_o), 64'd0);
      cycle();
      idle();
      chk({tag, "_pend1"}, 64'(rd_pending_o), 64'd1);
      out_r_valid = 1'b1; out_r_data = data; out_r_resp = 2'b00; out_r_last = 1'b1; in_r_ready = 1'b1;
      #1;
      chk({tag, "_r_data"}, 64'(in_r_data), 64'(data));
      chk({tag, "_r_resp"}, 64'(in_r_resp), 64'd0);
      cycle();
      idle();
      chk({tag, "_pend_end"}, 64'(rd_pending_o), 64'd0);
   endtask

   initial begin
      idle();
      rst_i = 1'b1;
      #2;
      chk("rst_rd_pend", 64'(rd_pending_o), 64'd0);
      chk("rst_wr_pend", 64'(wr_pending_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_valids", {out_ar_valid, out_aw_valid, out_w_valid}, 64'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      single_read("rd1", 32'h0000_1000, 32'hDEAD_BEEF);

      // Limit of two reads: the third AR stalls until an R frees a slot one cycle later
      idle();
      n_ar_hs = 0;
      in_ar_valid = 1'b1; in_ar_addr = 32'h2000; out_ar_ready = 1'b1;
      repeat (3) cycle();
      chk("full_ar_hs", 64'(n_ar_hs), 64'd2);
      #1 chk("full_ar_rdy", 64'(in_ar_ready), 64'd0);
      out_r_valid = 1'b1; in_r_ready = 1'b1; out_r_data = 32'h1234_5678;
      #1 chk("full_same_cycle_rdy", 64'(in_ar_ready), 64'd0);
      cycle();
      out_r_valid = 1'b0; in_r_ready = 1'b0;
      #1 chk("full_reopen_rdy", 64'(in_ar_ready), 64'd1);
      cycle();
      drain("full");

      // W leads AW by three cycles
      idle();
      in_w_valid = 1'b1; in_w_data = 32'h0000_55AA; in_w_strb = 4'h3;
      repeat (2) cycle();
      out_w_ready = 1'b1;
      #1;
      chk("w_first_vld", 64'(out_w_valid), 64'd1);
      chk("w_first_last", 64'(out_w_last), 64'd1);
      chk("w_first_data", {out_w_data, out_w_strb}, {32'h0000_55AA, 4'h3});
      cycle();
      idle();
      chk("w_first_aw_pend", 64'(wr_pending_o), 64'd0);
      in_aw_valid = 1'b1; in_aw_addr = 32'h3000; out_aw_ready = 1'b1;
      cycle();
      idle();
      chk("w_first_aw_pend1", 64'(wr_pending_o), 64'd1);
      out_b_valid = 1'b1; out_b_resp = 2'b10; in_b_ready = 1'b1;
      #1 chk("w_first_b_resp", 64'(in_b_resp), 64'd2);
      cycle();
      drain("w_first");

      // Simultaneous AR and R with one read outstanding
      idle();
      in_ar_valid = 1'b1; out_ar_ready = 1'b1;
      cycle();
      out_r_valid = 1'b1; in_r_ready = 1'b1;
      cycle();
      idle();
      chk("sim_rd_pend", 64'(rd_pending_o), 64'd1);
      chk("sim_err", 64'(err_o), 64'd0);
      drain("sim");

      // Random traffic; responses only for transactions the model holds outstanding
      for (int i = 0; i < 400; i++) begin
         idle();
         in_ar_valid = 1'($urandom_range(0, 1)); in_ar_addr = $urandom; in_ar_prot = 3'($urandom);
         in_aw_valid = 1'($urandom_range(0, 1)); in_aw_addr = $urandom; in_aw_prot = 3'($urandom);
         in_w_valid = 1'($urandom_range(0, 1)); in_w_data = $urandom; in_w_strb = 4'($urandom);
         out_ar_ready = 1'($urandom_range(0, 1));
         out_aw_ready = 1'($urandom_range(0, 1));
         out_w_ready = 1'($urandom_range(0, 1));
         out_r_valid = (m_rd > 0) && ($urandom_range(0, 2) != 0);
         out_r_data = $urandom; out_r_resp = 2'($urandom);
         in_r_ready = 1'($urandom_range(0, 1));
         out_b_valid = (m_aw > 0 && m_w > 0) && ($urandom_range(0, 2) != 0);
         out_b_resp = 2'($urandom);
         in_b_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      drain("rand");

      // B with nothing outstanding
      idle();
      out_b_valid = 1'b1; in_b_ready = 1'b1;
      cycle();
      idle();
      chk("orphan_b_err", 64'(err_o), 64'd1);
      chk("orphan_b_wr_pend", 64'(wr_pending_o), 64'd0);
      repeat (3) cycle();
      chk("orphan_b_sticky", 64'(err_o), 64'd1);

      // Asynchronous reset with a read in flight
      idle();
      in_ar_valid = 1'b1; out_ar_ready = 1'b1;
      cycle();
      idle();
      chk("arst_pre", 64'(rd_pending_o), 64'd1);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_rd_pend", 64'(rd_pending_o), 64'd0);
      chk("arst_err", 64'(err_o), 64'd0);
      m_rd = 0; m_aw = 0; m_w = 0; m_err = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      single_read("rd_post", 32'h0000_4000, 32'hCAFE_F00D);
      chk("rd_post_err", 64'(err_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
